// File: rtl/segcapture.sv
// segcapture: seven-segment readback decoder.
// Watches a time-multiplexed, active-low four-digit display bus. Each
// digit's (an, seg) pair has to stay unchanged for SETTLE+1 edges before
// it is sampled once. The sampled pattern is mapped back to its hex
// nibble. After all four digits are held, the 16-bit value and the
// decimal points are published together with a one-cycle valid pulse.
module segcapture #(
    parameter int unsigned SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] number,
    output logic [3:0]  dp,
    output logic        valid,
    output logic        err
);

    // cnt is 4 bits wide, which covers the legal SETTLE range 2..15.
    localparam logic [3:0] SETTLE_C  = 4'(SETTLE);
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    logic [3:0]  an_q;
    logic [7:0]  seg_q;
    logic [3:0]  cnt;

    logic [15:0] shadow;
    logic [3:0]  dpshadow;
    logic [3:0]  got;

    logic        same;
    logic        sel_one;
    logic [1:0]  sel_idx;
    logic [3:0]  sel_mask;
    logic        sample;
    logic        glyph_ok;
    logic [3:0]  glyph_nib;
    logic        blank;
    logic        complete;
    logic [3:0]  got_base;
    logic [3:0]  got_next;

    // Register the bus and count how long the current pair has been stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= 4'hF;
            seg_q <= 8'hFF;
            cnt   <= 4'd0;
        end else begin
            an_q  <= an;
            seg_q <= seg;
            if (!same) begin
                cnt <= 4'd0;
            end else if (cnt != SETTLE_C) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Find which digit is selected. Blanking and multi-select give no sample.
    always_comb begin
        sel_one  = 1'b1;
        sel_idx  = 2'd0;
        sel_mask = 4'b0000;
        unique case (an_q)
            4'b1110: begin sel_idx = 2'd0; sel_mask = 4'b0001; end
            4'b1101: begin sel_idx = 2'd1; sel_mask = 4'b0010; end
            4'b1011: begin sel_idx = 2'd2; sel_mask = 4'b0100; end
            4'b0111: begin sel_idx = 2'd3; sel_mask = 4'b1000; end
            default: sel_one = 1'b0;
        endcase
    end

    // Map the active-low segment pattern back to a hex nibble.
    always_comb begin
        glyph_ok  = 1'b1;
        glyph_nib = 4'h0;
        case (seg_q[6:0])
            7'h40: glyph_nib = 4'h0;
            7'h79: glyph_nib = 4'h1;
            7'h24: glyph_nib = 4'h2;
            7'h30: glyph_nib = 4'h3;
            7'h19: glyph_nib = 4'h4;
            7'h12: glyph_nib = 4'h5;
            7'h02: glyph_nib = 4'h6;
            7'h78: glyph_nib = 4'h7;
            7'h00: glyph_nib = 4'h8;
            7'h10: glyph_nib = 4'h9;
            7'h08: glyph_nib = 4'hA;
            7'h03: glyph_nib = 4'hB;
            7'h46: glyph_nib = 4'hC;
            7'h21: glyph_nib = 4'hD;
            7'h06: glyph_nib = 4'hE;
            7'h0E: glyph_nib = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

    // Sample qualification and next got vector. Completion clears got
    // first, so a sample that lands on the same edge still keeps its bit.
    always_comb begin
        same     = (an == an_q) && (seg == seg_q);
        blank    = (seg_q[6:0] == 7'h7F);
        sample   = sel_one && same && (cnt == SETTLE_M1);
        complete = (got == 4'hF);
        got_base = complete ? 4'h0 : got;
        got_next = got_base;
        if (sample && glyph_ok) begin
            got_next = got_base | sel_mask;
        end else if (sample && !blank) begin
            got_next = got_base & ~sel_mask;
        end
    end

    // Per-digit shadow capture and tracking of which digits have arrived.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= 16'h0000;
            dpshadow <= 4'h0;
            got      <= 4'h0;
        end else begin
            got <= got_next;
            if (sample && glyph_ok) begin
                shadow[4*sel_idx +: 4] <= glyph_nib;
                dpshadow[sel_idx]      <= ~seg_q[7];
            end
        end
    end

    // Publish a completed frame and generate the single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number <= 16'h0000;
            dp     <= 4'h0;
            valid  <= 1'b0;
            err    <= 1'b0;
        end else begin
            valid <= complete;
            err   <= sample && !glyph_ok && !blank;
            if (complete) begin
                number <= shadow;
                dp     <= dpshadow;
            end
        end
    end

endmodule

// File: tb/tb_segcapture.sv
// Bench for segcapture: drives display-bus frames and checks the
// published values through an expected-value queue.
module tb_segcapture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [7:0]  seg = 8'hFF;
    logic [15:0] number;
    logic [3:0]  dp;
    logic        valid;
    logic        err;

    int tests_run = 0;
    int failed = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    logic [19:0] exp_q[$];

    segcapture #(.SETTLE(4)) dut (
        .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
        .number(number), .dp(dp), .valid(valid), .err(err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every valid pulse pops one expected {dp, number}.
    always @(negedge clk) begin
        logic [19:0] e;
        if (valid === 1'b1) begin
            valid_cnt++;
            tests_run++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_valid got number=%h dp=%h, no result expected", number, dp);
            end else begin
                e = exp_q.pop_front();
                if ({dp, number} !== e) begin
                    failed++;
                    $display("FAIL frame_value got dp=%h number=%h want dp=%h number=%h",
                             dp, number, e[19:16], e[15:0]);
                end
            end
        end
        if (err === 1'b1) err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] t[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        an = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_digit(input int k, input logic [3:0] nib, input logic dpl, input int n);
        logic [3:0] a;
        a = 4'hF;
        a[k] = 1'b0;
        hold(a, {~dpl, glyph(nib)}, n);
    endtask

    task automatic test_reset;
        tests_run++;
        if (number !== 16'h0000) begin failed++; $display("FAIL reset_number got %h want 0000", number); end
        tests_run++;
        if (dp !== 4'h0) begin failed++; $display("FAIL reset_dp got %h want 0", dp); end
        tests_run++;
        if (valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b want 0", valid); end
        tests_run++;
        if (err !== 1'b0) begin failed++; $display("FAIL reset_err got %b want 0", err); end
    endtask

    task automatic test_full_frame;
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        exp_q.push_back({4'h0, 16'h1234});
        hold(4'b1110, 8'h99, 6);
        hold(4'b1101, 8'hB0, 6);
        hold(4'b1011, 8'hA4, 6);
        hold(4'b0111, 8'hF9, 5);
        tests_run++;
        if (valid !== 1'b0) begin failed++; $display("FAIL full_valid_early got %b want 0", valid); end
        @(negedge clk);
        tests_run++;
        if (valid !== 1'b1) begin failed++; $display("FAIL full_valid_timing got %b want 1", valid); end
        hold(4'hF, 8'hFF, 3);
        tests_run++;
        if (valid_cnt - v0 != 1) begin failed++; $display("FAIL full_valid_count got %0d want 1", valid_cnt - v0); end
        tests_run++;
        if (err_cnt != e0) begin failed++; $display("FAIL full_err got %0d pulses want 0", err_cnt - e0); end
        tests_run++;
        if (number !== 16'h1234) begin failed++; $display("FAIL full_number_hold got %h want 1234", number); end
    endtask

    task automatic test_glitch;
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        exp_q.push_back({4'h0, 16'h1234});
        hold(4'b1110, 8'h99, 6);
        hold(4'b1110, 8'hC0, 4);
        hold(4'b1101, 8'hB0, 6);
        hold(4'b1110, 8'hC0, 4);
        hold(4'b1011, 8'hA4, 6);
        hold(4'b0111, 8'hF9, 6);
        hold(4'hF, 8'hFF, 3);
        tests_run++;
        if (valid_cnt - v0 != 1) begin failed++; $display("FAIL glitch_valid_count got %0d want 1", valid_cnt - v0); end
        tests_run++;
        if (number[3:0] !== 4'h4) begin failed++; $display("FAIL glitch_digit0 got %h want 4", number[3:0]); end
        tests_run++;
        if (err_cnt != e0) begin failed++; $display("FAIL glitch_err got %0d pulses want 0", err_cnt - e0); end
    endtask

    task automatic test_invalid_glyph;
        int v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        hold(4'b1110, 8'hAA, 6);
        hold(4'b1101, 8'hB0, 6);
        hold(4'b1011, 8'hA4, 6);
        hold(4'b0111, 8'hF9, 6);
        hold(4'hF, 8'hFF, 4);
        tests_run++;
        if (err_cnt - e0 != 1) begin failed++; $display("FAIL invalid_err_count got %0d want 1", err_cnt - e0); end
        tests_run++;
        if (valid_cnt != v0) begin failed++; $display("FAIL invalid_no_valid got %0d pulses want 0", valid_cnt - v0); end
        exp_q.push_back({4'h0, 16'h1234});
        hold(4'b1110, 8'h99, 6);
        hold(4'hF, 8'hFF, 3);
        tests_run++;
        if (valid_cnt - v0 != 1) begin failed++; $display("FAIL invalid_resend_valid got %0d want 1", valid_cnt - v0); end
    endtask

    task automatic test_bus_conditions;
        int v0, e0;
        exp_q.push_back({4'h0, 16'h1234});
        for (int k = 0; k < 4; k++) send_digit(k, 4'(k == 0 ? 4 : 4 - k), 1'b0, 6);
        hold(4'hF, 8'hFF, 3);
        v0 = valid_cnt;
        e0 = err_cnt;
        hold(4'b1100, 8'hAA, 10);
        hold(4'b1111, 8'hAA, 10);
        tests_run++;
        if (err_cnt != e0) begin failed++; $display("FAIL bus_err got %0d pulses want 0", err_cnt - e0); end
        tests_run++;
        if (valid_cnt != v0) begin failed++; $display("FAIL bus_valid got %0d pulses want 0", valid_cnt - v0); end
        exp_q.push_back({4'hF, 16'hAFC0});
        hold(4'b0111, 8'h08, 6);
        hold(4'b1011, 8'h0E, 6);
        hold(4'b1101, 8'h46, 6);
        hold(4'b1110, 8'h40, 6);
        hold(4'hF, 8'hFF, 3);
        tests_run++;
        if (valid_cnt - v0 != 1) begin failed++; $display("FAIL bus_dp_valid got %0d want 1", valid_cnt - v0); end
        tests_run++;
        if (dp !== 4'hF) begin failed++; $display("FAIL bus_dp got %h want F", dp); end
    endtask

    task automatic test_reset_mid_frame;
        int v0;
        hold(4'b1110, 8'h99, 6);
        hold(4'b1101, 8'hB0, 6);
        hold(4'b1011, 8'hA4, 6);
        an = 4'hF;
        seg = 8'hFF;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests_run++;
        if (number !== 16'h0000) begin failed++; $display("FAIL rstmid_number got %h want 0000", number); end
        v0 = valid_cnt;
        hold(4'b0111, 8'hF9, 6);
        hold(4'hF, 8'hFF, 4);
        tests_run++;
        if (valid_cnt != v0) begin failed++; $display("FAIL rstmid_no_valid got %0d pulses want 0", valid_cnt - v0); end
        tests_run++;
        if (number !== 16'h0000) begin failed++; $display("FAIL rstmid_number_hold got %h want 0000", number); end
        exp_q.push_back({4'h0, 16'h1234});
        hold(4'b1110, 8'h99, 6);
        hold(4'b1101, 8'hB0, 6);
        hold(4'b1011, 8'hA4, 6);
        hold(4'hF, 8'hFF, 3);
        tests_run++;
        if (valid_cnt - v0 != 1) begin failed++; $display("FAIL rstmid_valid got %0d want 1", valid_cnt - v0); end
        // Digit 3 is left pending; the next test starts with digit 3 anyway.
        hold(4'b0111, 8'hF9, 6);
        hold(4'hF, 8'hFF, 2);
    endtask

    task automatic test_order_overwrite;
        int v0;
        v0 = valid_cnt;
        exp_q.push_back({4'h0, 16'h1237});
        // Minimum dwell of SETTLE+1 cycles per digit.
        hold(4'b0111, 8'hF9, 5);
        hold(4'b1101, 8'hB0, 5);
        hold(4'b1110, 8'h92, 5);
        hold(4'b1110, 8'hF8, 5);
        tests_run++;
        if (valid_cnt != v0) begin failed++; $display("FAIL order_early_valid got %0d pulses want 0", valid_cnt - v0); end
        hold(4'b1011, 8'hA4, 5);
        hold(4'hF, 8'hFF, 4);
        tests_run++;
        if (valid_cnt - v0 != 1) begin failed++; $display("FAIL order_valid_count got %0d want 1", valid_cnt - v0); end
        tests_run++;
        if (number[3:0] !== 4'h7) begin failed++; $display("FAIL order_nibble0 got %h want 7", number[3:0]); end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_full_frame;
        test_glitch;
        test_invalid_glyph;
        test_bus_conditions;
        test_reset_mid_frame;
        test_order_overwrite;
        tests_run++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL pending_results got %0d outstanding want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
